// File: rtl/input_conditioner.sv
// Input conditioner for board buttons and switches.
// Each channel has a metastability synchronizer, a debounce filter and registered
// rise/fall pulses. A pulse is asserted on the same edge that q changes.
module input_conditioner #(
    parameter int unsigned WIDTH           = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_rise
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;

    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           q_q, q_d;
    logic [WIDTH-1:0]           rise_q, rise_d;
    logic [WIDTH-1:0]           fall_q, fall_d;
    logic                       any_rise_q;

    // Synchronizer chain: plain flop-to-flop path, nothing in between stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: q takes s only after s has differed from q on DEBOUNCE_CYCLES
    // consecutive cycles; any agreeing cycle restarts the count.
    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == q_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                cnt_d[i]  = '0;
                q_d[i]    = s[i];
                rise_d[i] = s[i];
                fall_d[i] = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // Filter state and pulse registers; pulses share the edge of the q update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            q_q        <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            any_rise_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            any_rise_q <= |rise_d;
        end
    end

    assign q        = q_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign any_rise = any_rise_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: default instance plus a
// SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance, both fed from the same din.
module tb_input_conditioner;

    localparam int S0 = 2;
    localparam int D0 = 4;
    localparam int S1 = 3;
    localparam int D1 = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] din   = 5'b11111;

    logic [4:0] q1, rise1, fall1;
    logic       any1;
    logic [4:0] q2, rise2, fall2;
    logic       any2;

    int checks = 0;
    int errors = 0;
    int rise_ch2_seen = 0;

    // Model: delay line of din samples, and a window of synchronized samples.
    logic [4:0] hist  [2][16];
    logic [4:0] shist [2][16];
    logic [4:0] mq    [2];
    logic [4:0] mrise [2];
    logic [4:0] mfall [2];
    logic       many  [2];

    input_conditioner #(
        .WIDTH          (5),
        .SYNC_STAGES    (S0),
        .DEBOUNCE_CYCLES(D0)
    ) dut1 (
        .clock   (clock),
        .reset   (reset),
        .din     (din),
        .q       (q1),
        .rise    (rise1),
        .fall    (fall1),
        .any_rise(any1)
    );

    input_conditioner #(
        .WIDTH          (5),
        .SYNC_STAGES    (S1),
        .DEBOUNCE_CYCLES(D1)
    ) dut2 (
        .clock   (clock),
        .reset   (reset),
        .din     (din),
        .q       (q2),
        .rise    (rise2),
        .fall    (fall2),
        .any_rise(any2)
    );

    always #5 clock = ~clock;

    task automatic expect_v(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) begin
                hist[m][k]  = '0;
                shist[m][k] = '0;
            end
            mq[m]    = '0;
            mrise[m] = '0;
            mfall[m] = '0;
            many[m]  = 1'b0;
        end
    endtask

    // s seen at this edge is din captured sn edges earlier; q flips once the
    // last dn values of s all disagree with q.
    task automatic model_step(input int m, input int sn, input int dn, input logic [4:0] d);
        logic [4:0] s_now;
        logic [4:0] nq;
        bit         flip;
        s_now = hist[m][sn-1];
        for (int k = 15; k > 0; k--) begin
            hist[m][k]  = hist[m][k-1];
            shist[m][k] = shist[m][k-1];
        end
        hist[m][0]  = d;
        shist[m][0] = s_now;
        nq = mq[m];
        for (int i = 0; i < 5; i++) begin
            flip = 1'b1;
            for (int k = 0; k < dn; k++) begin
                if (shist[m][k][i] == mq[m][i]) flip = 1'b0;
            end
            if (flip) nq[i] = ~mq[m][i];
        end
        mrise[m] = nq & ~mq[m];
        mfall[m] = ~nq & mq[m];
        many[m]  = |mrise[m];
        mq[m]    = nq;
    endtask

    initial model_reset();

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            model_step(0, S0, D0, din);
            model_step(1, S1, D1, din);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(posedge clock) begin
        #1;
        expect_v("dut1 q", q1, mq[0]);
        expect_v("dut1 rise", rise1, mrise[0]);
        expect_v("dut1 fall", fall1, mfall[0]);
        expect_v("dut1 any_rise", {4'b0, any1}, {4'b0, many[0]});
        expect_v("dut2 q", q2, mq[1]);
        expect_v("dut2 rise", rise2, mrise[1]);
        expect_v("dut2 fall", fall2, mfall[1]);
        expect_v("dut2 any_rise", {4'b0, any2}, {4'b0, many[1]});
        if (rise1[2] === 1'b1) rise_ch2_seen++;
    end

    task automatic at_edge(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clock);
    endtask

    initial begin
        // 1: reset held with all inputs high, then release
        idle(5);
        expect_v("rst q", q1, 5'b00000);
        expect_v("rst rise", rise1, 5'b00000);
        expect_v("rst fall", fall1, 5'b00000);
        expect_v("rst any_rise", {4'b0, any1}, 5'b00000);
        reset = 1'b0;
        at_edge(5);
        expect_v("rel q edge5", q1, 5'b00000);
        at_edge(1);
        expect_v("rel q edge6", q1, 5'b11111);
        expect_v("rel rise edge6", rise1, 5'b11111);
        expect_v("rel any edge6", {4'b0, any1}, 5'b00001);
        at_edge(1);
        expect_v("rel rise edge7", rise1, 5'b00000);
        expect_v("rel any edge7", {4'b0, any1}, 5'b00000);

        @(negedge clock) din = 5'b00000;
        idle(10);

        // 2: clean press/release on channel 3, both parameter sets
        @(negedge clock) din = 5'b01000;
        at_edge(3);
        expect_v("sweep rise edge3", rise2, 5'b00000);
        at_edge(1);
        expect_v("sweep q edge4", q2, 5'b01000);
        expect_v("sweep rise edge4", rise2, 5'b01000);
        at_edge(1);
        expect_v("sweep rise edge5", rise2, 5'b00000);
        expect_v("press q edge5", q1, 5'b00000);
        expect_v("press rise edge5", rise1, 5'b00000);
        at_edge(1);
        expect_v("press q edge6", q1, 5'b01000);
        expect_v("press rise edge6", rise1, 5'b01000);
        at_edge(1);
        expect_v("press rise edge7", rise1, 5'b00000);
        idle(13);
        din = 5'b00000;
        at_edge(5);
        expect_v("release q edge5", q1, 5'b01000);
        expect_v("release fall edge5", fall1, 5'b00000);
        at_edge(1);
        expect_v("release q edge6", q1, 5'b00000);
        expect_v("release fall edge6", fall1, 5'b01000);
        at_edge(1);
        expect_v("release fall edge7", fall1, 5'b00000);
        idle(4);

        // 3: bounce on channel 2 with 2-cycle periods, then stable high
        @(negedge clock) rise_ch2_seen = 0;
        for (int b = 0; b < 4; b++) begin
            din[2] = (b % 2 == 0);
            idle(2);
        end
        din[2] = 1'b1;
        at_edge(5);
        expect_v("bounce rise edge5", rise1, 5'b00000);
        at_edge(1);
        expect_v("bounce rise edge6", rise1, 5'b00100);
        at_edge(1);
        expect_i("bounce rise count", rise_ch2_seen, 1);
        @(negedge clock) din = 5'b00000;
        idle(10);

        // 4: 3-cycle glitch on channel 1 never reaches q
        for (int g = 0; g < 12; g++) begin
            @(negedge clock) din[1] = (g < 3);
            at_edge(1);
            expect_v("glitch ch1", {2'b0, q1[1], rise1[1], fall1[1]}, 5'b00000);
        end

        // 5: simultaneous rises on 0 and 4 with a fall on 1
        @(negedge clock) din = 5'b00010;
        idle(10);
        expect_v("simul pre q", q1, 5'b00010);
        din = 5'b10001;
        at_edge(5);
        expect_v("simul rise edge5", rise1, 5'b00000);
        at_edge(1);
        expect_v("simul rise edge6", rise1, 5'b10001);
        expect_v("simul fall edge6", fall1, 5'b00010);
        expect_v("simul any edge6", {4'b0, any1}, 5'b00001);
        at_edge(1);
        expect_v("simul rise edge7", rise1, 5'b00000);
        expect_v("simul fall edge7", fall1, 5'b00000);
        @(negedge clock) din = 5'b00000;
        idle(10);

        // 6: reset pulse during debounce of channel 3
        @(negedge clock) din = 5'b01000;
        at_edge(3);
        expect_v("middeb rise edge3", rise1, 5'b00000);
        @(negedge clock) reset = 1'b1;
        at_edge(1);
        expect_v("middeb q in reset", q1, 5'b00000);
        expect_v("middeb rise in reset", rise1, 5'b00000);
        @(negedge clock) reset = 1'b0;
        at_edge(5);
        expect_v("middeb q edge5", q1, 5'b00000);
        at_edge(1);
        expect_v("middeb q edge6", q1, 5'b01000);
        expect_v("middeb rise edge6", rise1, 5'b01000);
        at_edge(1);
        expect_v("middeb rise edge7", rise1, 5'b00000);

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
